// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the img_block + convolutor pair: scans the image RAM in raster
// order, aligns the convolutor enable to RAM read data and tags every real window result.
module conv_frame_sequencer #(
    parameter int N          = 100,
    parameter int K_SIZE     = 3,
    parameter int ADDR_WIDTH = 14,
    parameter int CONV_LAT   = 1,
    parameter int COORD_W    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  hold_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  conv_en_o,
    output logic                  win_valid_o,
    output logic [COORD_W-1:0]    out_row_o,
    output logic [COORD_W-1:0]    out_col_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(N * N - 1);
    localparam logic [COORD_W-1:0]    LAST_COORD = COORD_W'(N - 1);
    localparam logic [COORD_W-1:0]    EDGE       = COORD_W'(K_SIZE - 1);
    localparam logic [COORD_W:0]      KS         = (COORD_W + 1)'(K_SIZE);

    state_t                state, state_next;
    logic                  issue;
    logic                  pending;
    logic                  win_hit;
    logic [ADDR_WIDTH-1:0] issue_cnt;
    logic [COORD_W-1:0]    pix_row, pix_col;
    logic [CONV_LAT-1:0]   vld;
    logic [COORD_W-1:0]    row_pipe [CONV_LAT];
    logic [COORD_W-1:0]    col_pipe [CONV_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE:  if (start_i) state_next = FETCH;
            FETCH: if (!hold_i) begin
                issue = 1'b1;
                if (issue_cnt == LAST_ADDR) state_next = DRAIN;
            end
            DRAIN: if (!mem_en_o && !conv_en_o && !pending) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Window results still inside the delay line, excluding the one being presented now.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < CONV_LAT - 1; i++) pending = pending | vld[i];
    end

    // Pixel is the bottom-right corner of a full window: row >= K-1 and col >= K-1.
    assign win_hit = conv_en_o
                   && (({1'b0, pix_row} + 1'b1) >= KS)
                   && (({1'b0, pix_col} + 1'b1) >= KS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt  <= '0;
            mem_en_o   <= 1'b0;
            mem_addr_o <= '0;
            conv_en_o  <= 1'b0;
            pix_row    <= '0;
            pix_col    <= '0;
        end else begin
            mem_en_o  <= issue;
            conv_en_o <= mem_en_o;
            if (state == IDLE) begin
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (issue)               mem_addr_o <= issue_cnt;
            else if (state == DONE)  mem_addr_o <= '0;
            if (state == IDLE) begin
                pix_row <= '0;
                pix_col <= '0;
            end else if (conv_en_o) begin
                if (pix_col == LAST_COORD) begin
                    pix_col <= '0;
                    pix_row <= pix_row + 1'b1;
                end else begin
                    pix_col <= pix_col + 1'b1;
                end
            end
        end
    end

    // conv_en_o means RAM data is valid this cycle; win_valid_o means the convolutor
    // data_o is a real window result this cycle. Neither has backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < CONV_LAT; i++) begin
                row_pipe[i] <= '0;
                col_pipe[i] <= '0;
            end
        end else begin
            vld[0]      <= win_hit;
            row_pipe[0] <= win_hit ? pix_row - EDGE : '0;
            col_pipe[0] <= win_hit ? pix_col - EDGE : '0;
            for (int i = 1; i < CONV_LAT; i++) begin
                vld[i]      <= vld[i-1];
                row_pipe[i] <= row_pipe[i-1];
                col_pipe[i] <= col_pipe[i-1];
            end
        end
    end

    assign win_valid_o = vld[CONV_LAT-1];
    assign out_row_o   = row_pipe[CONV_LAT-1];
    assign out_col_o   = col_pipe[CONV_LAT-1];
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer: an N=5/K=3/LAT=1 instance and an N=4/K=1/LAT=3 instance,
// with expected addresses, window results and done pulses queued and checked by monitors.
module tb_conv_frame_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    // instance A: N=5, K=3, CONV_LAT=1
    logic        start_a, hold_a;
    logic        mem_en_a, conv_en_a, win_valid_a, busy_a, done_a;
    logic [13:0] mem_addr_a;
    logic [2:0]  out_row_a, out_col_a;

    conv_frame_sequencer #(.N(5), .K_SIZE(3), .ADDR_WIDTH(14), .CONV_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .hold_i(hold_a),
        .mem_en_o(mem_en_a), .mem_addr_o(mem_addr_a), .conv_en_o(conv_en_a),
        .win_valid_o(win_valid_a), .out_row_o(out_row_a), .out_col_o(out_col_a),
        .busy_o(busy_a), .done_o(done_a)
    );

    // instance B: N=4, K=1, CONV_LAT=3
    logic        start_b, hold_b;
    logic        mem_en_b, conv_en_b, win_valid_b, busy_b, done_b;
    logic [13:0] mem_addr_b;
    logic [1:0]  out_row_b, out_col_b;

    conv_frame_sequencer #(.N(4), .K_SIZE(1), .ADDR_WIDTH(14), .CONV_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .hold_i(hold_b),
        .mem_en_o(mem_en_b), .mem_addr_o(mem_addr_b), .conv_en_o(conv_en_b),
        .win_valid_o(win_valid_b), .out_row_o(out_row_b), .out_col_o(out_col_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    // scoreboard entries: {cycle[15:0], row[7:0], col[7:0]} and {cycle[15:0], addr[15:0]}
    logic [31:0] win_q[$];
    logic [31:0] adr_q[$];
    logic [31:0] done_q[$];
    logic [31:0] winb_q[$];
    logic [31:0] doneb_q[$];
    int t0_a = 0, t0_b = 0;
    int nwin_a = 0, nwin_b = 0;
    bit busy_chk_a = 0, busy_chk_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor A
    always @(negedge clk) begin
        if (rst_n) begin
            automatic int rel = cyc - t0_a;
            automatic logic [31:0] e;
            if (mem_en_a) begin
                if (adr_q.size() == 0) chk("a_addr_unexpected", int'(mem_addr_a), -1);
                else begin
                    e = adr_q.pop_front();
                    chk("a_addr_cycle", rel, int'(e[31:16]));
                    chk("a_addr_value", int'(mem_addr_a), int'(e[15:0]));
                end
            end
            if (win_valid_a) begin
                nwin_a++;
                if (win_q.size() == 0) chk("a_win_unexpected", rel, -1);
                else begin
                    e = win_q.pop_front();
                    chk("a_win_cycle", rel, int'(e[31:16]));
                    chk("a_win_row", int'(out_row_a), int'(e[15:8]));
                    chk("a_win_col", int'(out_col_a), int'(e[7:0]));
                end
            end else if (out_row_a != 0 || out_col_a != 0) begin
                chk("a_coord_idle", int'({out_row_a, out_col_a}), 0);
            end
            if (done_a) begin
                chk("a_busy_at_done", int'(busy_a), 1);
                busy_chk_a = 1;
                if (done_q.size() == 0) chk("a_done_unexpected", rel, -1);
                else chk("a_done_cycle", rel, int'(done_q.pop_front()));
            end else if (busy_chk_a) begin
                chk("a_busy_after_done", int'(busy_a), 0);
                busy_chk_a = 0;
            end
        end
    end

    // monitor B
    always @(negedge clk) begin
        if (rst_n) begin
            automatic int rel = cyc - t0_b;
            automatic logic [31:0] e;
            if (win_valid_b) begin
                nwin_b++;
                if (winb_q.size() == 0) chk("b_win_unexpected", rel, -1);
                else begin
                    e = winb_q.pop_front();
                    chk("b_win_cycle", rel, int'(e[31:16]));
                    chk("b_win_row", int'(out_row_b), int'(e[15:8]));
                    chk("b_win_col", int'(out_col_b), int'(e[7:0]));
                end
            end
            if (done_b) begin
                busy_chk_b = 1;
                if (doneb_q.size() == 0) chk("b_done_unexpected", rel, -1);
                else chk("b_done_cycle", rel, int'(doneb_q.pop_front()));
            end else if (busy_chk_b) begin
                chk("b_busy_after_done", int'(busy_b), 0);
                busy_chk_b = 0;
            end
        end
    end

    // Hand-computed N=5/K=3 frame: addr k at cycle k+1, windows at the cycles below,
    // done at 28. A hold of 'shift' edges starting at edge 5 delays everything from addr 4.
    task automatic push_frame_a(input int offset, input int shift);
        int wc[9] = '{15, 16, 17, 20, 21, 22, 25, 26, 27};
        for (int k = 0; k < 25; k++)
            adr_q.push_back({16'(offset + k + 1 + ((k >= 4) ? shift : 0)), 16'(k)});
        for (int w = 0; w < 9; w++)
            win_q.push_back({16'(offset + wc[w] + shift), 8'(w / 3), 8'(w % 3)});
        done_q.push_back(32'(offset + 28 + shift));
    endtask

    task automatic start_a_pulse();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        t0_a = cyc;
        nwin_a = 0;
        start_a = 1'b0;
    endtask

    task automatic drain_a(input int nframes);
        for (int i = 0; i < 400 && done_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("a_done_q_empty", done_q.size(), 0);
        chk("a_win_q_empty", win_q.size(), 0);
        chk("a_adr_q_empty", adr_q.size(), 0);
        chk("a_win_count", nwin_a, 9 * nframes);
        chk("a_idle_busy", int'(busy_a), 0);
        chk("a_idle_addr", int'(mem_addr_a), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; hold_a = 1'b0;
        start_b = 1'b0; hold_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_outputs", int'({mem_en_a, mem_addr_a, conv_en_a, win_valid_a,
                                   out_row_a, out_col_a, busy_a, done_a}), 0);
        chk("rst_b_outputs", int'({mem_en_b, mem_addr_b, conv_en_b, win_valid_b,
                                   out_row_b, out_col_b, busy_b, done_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // plain frame
        start_a_pulse();
        push_frame_a(0, 0);
        drain_a(1);

        // hold during edges 5..7
        start_a_pulse();
        push_frame_a(0, 3);
        repeat (4) @(negedge clk);
        hold_a = 1'b1;
        repeat (3) @(negedge clk);
        hold_a = 1'b0;
        drain_a(1);

        // start while busy is ignored
        start_a_pulse();
        push_frame_a(0, 0);
        repeat (9) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        drain_a(1);

        // reset mid-frame in cycle 12, then a clean frame
        start_a_pulse();
        push_frame_a(0, 0);
        repeat (12) @(negedge clk);
        chk("a_busy_before_reset", int'(busy_a), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("a_async_reset_outputs", int'({mem_en_a, mem_addr_a, conv_en_a, win_valid_a,
                                           out_row_a, out_col_a, busy_a, done_a}), 0);
        win_q.delete(); adr_q.delete(); done_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_a_pulse();
        push_frame_a(0, 0);
        drain_a(1);

        // back-to-back with start held: second frame sampled at edge 30
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        t0_a = cyc;
        nwin_a = 0;
        push_frame_a(0, 0);
        push_frame_a(30, 0);
        repeat (35) @(negedge clk);
        start_a = 1'b0;
        drain_a(2);

        // instance B: every pixel is a window, result 3 cycles after consumption
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        t0_b = cyc;
        start_b = 1'b0;
        for (int p = 0; p < 16; p++)
            winb_q.push_back({16'(p + 5), 8'(p / 4), 8'(p % 4)});
        doneb_q.push_back(32'd21);
        for (int i = 0; i < 400 && doneb_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("b_done_q_empty", doneb_q.size(), 0);
        chk("b_win_q_empty", winb_q.size(), 0);
        chk("b_win_count", nwin_b, 16);
        chk("a_quiet_during_b", nwin_a, 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
